fifo_checker: RTL and testbench
===============================

Name: fifo_checker

Overview:
AXI4-Stream slave that consumes the counting-pattern stream produced by the team's stream loader and verifies it. Checks that each frame carries words 0..LENGTH-1 in order, with TLAST on the final word only. Counts good frames and erroneous beats, holds sticky error flags, and can apply periodic backpressure to exercise the source's TREADY handling. Sits between the loader (or the FIFO it feeds) and the MicroBlaze status registers.

Parameters:
DATA_WIDTH, 32, width of s_tdata; the expected word value is zero-extended to this width.
LENGTH, 32, words per frame; must be at least 2.
READY_PERIOD, 0, 0 = TREADY held high while enabled; N >= 2 = TREADY dropped for 1 cycle in every N.
CNT_WIDTH, 32, width of frame_count and error_count.

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
s_tdata  in  DATA_WIDTH  AXIS TDATA
s_tlast  in  1  AXIS TLAST
s_tvalid  in  1  AXIS TVALID
s_tready  out  1  AXIS TREADY, registered
enable  in  1  1 = accept beats; 0 = s_tready low
clear  in  1  synchronous clear of counters, flags and lock; single-cycle pulse
locked  out  1  1 = aligned to frame boundary and checking
frame_count  out  CNT_WIDTH  accepted TLAST beats while locked; saturating
error_count  out  CNT_WIDTH  beats with any error while locked; saturating
data_err  out  1  sticky: data mismatch seen
last_err  out  1  sticky: TLAST misplaced or missing

Behaviour:
- Reset (rstn low, asynchronous): s_tready=0, locked=0, counters=0, flags=0, exp=0, throttle counter=0, state=SYNC.
- Beat accepted = s_tvalid & s_tready in the same cycle. Registers update on the following clock edge.
- s_tready register: next = enable & ~(READY_PERIOD>=2 & thr==READY_PERIOD-1). thr is a free-running 0..READY_PERIOD-1 counter that wraps to 0. Enable changes show on s_tready one cycle later.
- The source may hold TVALID high indefinitely. Data is never consumed without s_tready.
- States: SYNC (locked=0) and CHECK (locked=1).
- SYNC: accepted beats are not checked and not counted. An accepted beat with s_tlast=1 → CHECK, exp=0.
- CHECK, per accepted beat, with exp = internal word index 0..LENGTH-1:
  - Data error if s_tdata != exp. Sets data_err.
  - Last error if s_tlast != (exp==LENGTH-1). Sets last_err.
  - error_count += 1 if either error (one per beat, even if both).
  - s_tlast=1: frame_count += 1 and exp → 0, including early TLAST.
  - s_tlast=0 and exp==LENGTH-1 (missing TLAST): → SYNC, exp=0, no frame count.
  - Otherwise exp += 1.
- Counters saturate at all-ones and do not wrap. Sticky flags clear only on reset or clear.
- clear=1: counters, flags and exp go to 0, and state → SYNC. It overrides a beat accepted in the same cycle, and that beat is dropped from checking. s_tready is unaffected by clear.
- Reset mid-frame: immediate return to reset values. Resynchronisation is required on the next TLAST.

Test Plan:
- LENGTH=32, READY_PERIOD=0, loader-style source starting at word 0 after reset, 3 frames → frame 1 used for sync; locked=1 after first TLAST; frame_count=2; error_count=0; flags 0.
- Locked; corrupt word 5 of one frame to 0xDEADBEEF → error_count=1, data_err=1, last_err=0; frame_count still increments for that frame.
- Locked; TLAST asserted on word 10 → last_err=1, error_count=1, frame_count+1, next beat (tdata 0) checked as word 0.
- Locked; TLAST dropped on word 31 → error_count=1, last_err=1, locked=0 next cycle; relock on the following TLAST.
- READY_PERIOD=4, continuous TVALID → s_tready low exactly 1 cycle in 4; no beat lost or duplicated; error_count=0. Set enable=0 → s_tready=0 from the next cycle.
- Pulse clear, and separately assert rstn low mid-frame → all counters and flags 0, locked=0; error_count saturation checked with CNT_WIDTH=4 → holds at 15.

Source files
------------

// File: rtl/fifo_checker.sv
// AXI4-Stream sink that verifies the loader's counting pattern (0..LENGTH-1 per frame,
// TLAST on the final word) and reports good frames, erroneous beats and sticky error flags.
module fifo_checker #(
  parameter int DATA_WIDTH   = 32,
  parameter int LENGTH       = 32,
  parameter int READY_PERIOD = 0,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  enable,
  input  logic                  clear,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic                  data_err,
  output logic                  last_err
);

  localparam int EXP_W = (LENGTH > 2) ? $clog2(LENGTH) : 1;
  localparam int THR_W = (READY_PERIOD > 2) ? $clog2(READY_PERIOD) : 1;

  typedef enum logic {SYNC, CHECK} state_t;

  state_t               r_state;
  logic                 r_locked;
  logic                 r_tready;
  logic [THR_W-1:0]     r_thr;
  logic [EXP_W-1:0]     r_exp;
  logic [CNT_WIDTH-1:0] r_frame_count;
  logic [CNT_WIDTH-1:0] r_error_count;
  logic                 r_data_err;
  logic                 r_last_err;

  logic w_accept;
  logic w_thr_wrap;
  logic w_last_pos;
  logic w_derr;
  logic w_lerr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_accept   = s_tvalid & r_tready;
  assign w_thr_wrap = (READY_PERIOD >= 2) && (r_thr == THR_W'(READY_PERIOD - 1));
  assign w_last_pos = (r_exp == EXP_W'(LENGTH - 1));
  assign w_derr     = (s_tdata != DATA_WIDTH'(r_exp));
  assign w_lerr     = (s_tlast != w_last_pos);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= SYNC;
      r_locked      <= 1'b0;
      r_tready      <= 1'b0;
      r_thr         <= '0;
      r_exp         <= '0;
      r_frame_count <= '0;
      r_error_count <= '0;
      r_data_err    <= 1'b0;
      r_last_err    <= 1'b0;
    end else begin
      // Throttle runs free of enable and clear so the gap cadence never shifts.
      r_tready <= enable & ~w_thr_wrap;
      if (READY_PERIOD >= 2)
        r_thr <= w_thr_wrap ? '0 : r_thr + THR_W'(1);
      else
        r_thr <= '0;

      if (clear) begin
        r_state       <= SYNC;
        r_locked      <= 1'b0;
        r_exp         <= '0;
        r_frame_count <= '0;
        r_error_count <= '0;
        r_data_err    <= 1'b0;
        r_last_err    <= 1'b0;
      end else if (w_accept) begin
        case (r_state)
          SYNC: begin
            if (s_tlast) begin
              r_state  <= CHECK;
              r_locked <= 1'b1;
              r_exp    <= '0;
            end
          end
          CHECK: begin
            if (w_derr) r_data_err <= 1'b1;
            if (w_lerr) r_last_err <= 1'b1;
            if (w_derr | w_lerr) r_error_count <= sat_inc(r_error_count);
            if (s_tlast) begin
              r_frame_count <= sat_inc(r_frame_count);
              r_exp         <= '0;
            end else if (w_last_pos) begin
              // Missing TLAST: frame alignment is lost, wait for the next TLAST.
              r_state  <= SYNC;
              r_locked <= 1'b0;
              r_exp    <= '0;
            end else begin
              r_exp <= r_exp + EXP_W'(1);
            end
          end
          default: begin
            r_state  <= SYNC;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_tready    = r_tready;
  assign locked      = r_locked;
  assign frame_count = r_frame_count;
  assign error_count = r_error_count;
  assign data_err    = r_data_err;
  assign last_err    = r_last_err;

endmodule

// File: tb/tb_fifo_checker.sv
// Directed bench: DUT A (LENGTH=32, no throttle) for pattern checks, DUT B (LENGTH=4,
// READY_PERIOD=4, CNT_WIDTH=4) for TREADY cadence and counter saturation.
module tb_fifo_checker;

  logic clk;
  logic rstn;

  logic [31:0] a_tdata;
  logic        a_tlast, a_tvalid, a_tready, a_enable, a_clear, a_locked;
  logic [31:0] a_frame_count, a_error_count;
  logic        a_data_err, a_last_err;

  logic [31:0] b_tdata;
  logic        b_tlast, b_tvalid, b_tready, b_enable, b_clear, b_locked;
  logic [3:0]  b_frame_count, b_error_count;
  logic        b_data_err, b_last_err;

  int checks;
  int failures;

  fifo_checker #(.DATA_WIDTH(32), .LENGTH(32), .READY_PERIOD(0), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rstn(rstn), .s_tdata(a_tdata), .s_tlast(a_tlast), .s_tvalid(a_tvalid),
    .s_tready(a_tready), .enable(a_enable), .clear(a_clear), .locked(a_locked),
    .frame_count(a_frame_count), .error_count(a_error_count),
    .data_err(a_data_err), .last_err(a_last_err)
  );

  fifo_checker #(.DATA_WIDTH(32), .LENGTH(4), .READY_PERIOD(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rstn(rstn), .s_tdata(b_tdata), .s_tlast(b_tlast), .s_tvalid(b_tvalid),
    .s_tready(b_tready), .enable(b_enable), .clear(b_clear), .locked(b_locked),
    .frame_count(b_frame_count), .error_count(b_error_count),
    .data_err(b_data_err), .last_err(b_last_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat_a(input logic [31:0] d, input logic l);
    bit acc;
    bit done;
    int n;
    a_tdata = d; a_tlast = l; a_tvalid = 1'b1;
    done = 1'b0; n = 0;
    while (!done) begin
      acc = a_tready;
      @(posedge clk); #1;
      if (acc) done = 1'b1;
      else begin
        n++;
        if (n > 50) begin
          checks++; failures++;
          $display("FAIL beat_a_timeout: observed no s_tready expected s_tready within 50 cycles");
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle_a();
    a_tvalid = 1'b0; a_tlast = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic frame_a(input int corrupt, input int early, input int drop);
    logic [31:0] d;
    logic        l;
    for (int w = 0; w < 32; w++) begin
      d = 32'(w);
      l = (w == 31);
      if (w == corrupt) d = 32'hDEADBEEF;
      if (w == drop) l = 1'b0;
      if (w == early) l = 1'b1;
      beat_a(d, l);
      if (w == early) break;
    end
  endtask

  task automatic b_stream(input int ncyc, input bit corrupt, output int lows, output int beats);
    int idx;
    bit acc;
    logic [31:0] w;
    idx = 0; lows = 0;
    for (int c = 0; c < ncyc; c++) begin
      w = 32'(idx % 4);
      b_tdata  = (corrupt && idx >= 4) ? (w | 32'h1000) : w;
      b_tlast  = (w == 32'd3);
      b_tvalid = 1'b1;
      acc = b_tready;
      if (!acc) lows++;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    b_tvalid = 1'b0; b_tlast = 1'b0;
    beats = idx;
  endtask

  initial begin
    int lows, beats, highs;
    checks = 0; failures = 0;
    rstn = 1'b0;
    a_tdata = '0; a_tlast = 1'b0; a_tvalid = 1'b0; a_enable = 1'b1; a_clear = 1'b0;
    b_tdata = '0; b_tlast = 1'b0; b_tvalid = 1'b0; b_enable = 1'b1; b_clear = 1'b0;

    #12;
    chk("rst_tready", a_tready, 0);
    chk("rst_locked", a_locked, 0);
    chk("rst_fc", a_frame_count, 0);
    chk("rst_ec", a_error_count, 0);
    chk("rst_flags", {a_data_err, a_last_err}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("tready_after_rst", a_tready, 1);

    // Three clean frames: first one only aligns.
    frame_a(-1, -1, -1);
    chk("locked_after_first_tlast", a_locked, 1);
    chk("fc_after_sync", a_frame_count, 0);
    frame_a(-1, -1, -1);
    frame_a(-1, -1, -1);
    idle_a();
    chk("clean_fc", a_frame_count, 2);
    chk("clean_ec", a_error_count, 0);
    chk("clean_flags", {a_data_err, a_last_err}, 0);

    frame_a(5, -1, -1);
    idle_a();
    chk("corrupt_fc", a_frame_count, 3);
    chk("corrupt_ec", a_error_count, 1);
    chk("corrupt_data_err", a_data_err, 1);
    chk("corrupt_last_err", a_last_err, 0);

    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    chk("clear_counts", {a_frame_count, a_error_count}, 0);
    chk("clear_flags", {a_data_err, a_last_err}, 0);
    chk("clear_locked", a_locked, 0);
    chk("clear_tready", a_tready, 1);

    // Resync, then an early TLAST on word 10.
    frame_a(-1, -1, -1);
    chk("relock_after_clear", a_locked, 1);
    frame_a(-1, 10, -1);
    chk("early_fc", a_frame_count, 1);
    chk("early_ec", a_error_count, 1);
    chk("early_last_err", a_last_err, 1);
    chk("early_data_err", a_data_err, 0);
    frame_a(-1, -1, -1);
    chk("after_early_fc", a_frame_count, 2);
    chk("after_early_ec", a_error_count, 1);

    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    frame_a(-1, -1, -1);
    frame_a(-1, -1, 31);
    chk("drop_locked", a_locked, 0);
    chk("drop_ec", a_error_count, 1);
    chk("drop_last_err", a_last_err, 1);
    chk("drop_fc", a_frame_count, 0);
    frame_a(-1, -1, -1);
    chk("drop_relock", a_locked, 1);
    chk("drop_relock_fc", a_frame_count, 0);
    frame_a(-1, -1, -1);
    idle_a();
    chk("drop_after_fc", a_frame_count, 1);
    chk("drop_after_ec", a_error_count, 1);

    // Throttled source: one gap in four, no beat lost or repeated.
    b_stream(40, 1'b0, lows, beats);
    chk("b_lows", 64'(lows), 10);
    chk("b_beats", 64'(beats), 30);
    chk("b_fc", b_frame_count, 4'(beats / 4 - 1));
    chk("b_ec", b_error_count, 0);
    chk("b_locked", b_locked, 1);

    b_enable = 1'b0;
    @(posedge clk); #1;
    chk("b_disable_tready", b_tready, 0);
    highs = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (b_tready) highs++;
    end
    chk("b_disable_hold", 64'(highs), 0);
    b_enable = 1'b1;

    b_clear = 1'b1;
    @(posedge clk); #1;
    b_clear = 1'b0;
    chk("b_clear_counts", {b_frame_count, b_error_count}, 0);
    chk("b_clear_locked", b_locked, 0);
    @(posedge clk); #1;

    b_stream(40, 1'b1, lows, beats);
    chk("b_sat_ec", b_error_count, 4'hF);
    chk("b_sat_fc", b_frame_count, 4'(beats / 4 - 1));
    chk("b_sat_data_err", b_data_err, 1);
    chk("b_sat_last_err", b_last_err, 0);

    // Asynchronous reset in the middle of a frame.
    for (int w = 0; w < 10; w++) beat_a(32'(w), 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_tready", a_tready, 0);
    chk("midrst_locked", a_locked, 0);
    chk("midrst_counts", {a_frame_count, a_error_count}, 0);
    chk("midrst_flags", {a_data_err, a_last_err}, 0);
    chk("midrst_b_counts", {b_frame_count, b_error_count}, 0);
    a_tvalid = 1'b0;
    #3;
    rstn = 1'b1;
    for (int w = 10; w < 20; w++) beat_a(32'(w), 1'b0);
    idle_a();
    chk("midrst_unlocked", a_locked, 0);
    chk("midrst_ec_stays", a_error_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
